// File: rtl/tb_collision_sched.sv
// Tank/bullet collision scheduler: snapshots one frame, tests one bullet slot per cycle.
// Optional TB_SCHED_EARLY_EXIT_EN: end the scan the cycle after the first hit.
module tb_collision_sched #(
  parameter int unsigned NUM_BULLETS = 12,
  parameter int unsigned COORD_W     = 10
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             Tank_X_Pos,
  input  logic [COORD_W-1:0]             Tank_Y_Pos,
  input  logic [COORD_W-1:0]             Tank_Size,
  input  logic [COORD_W*NUM_BULLETS-1:0] bullet_x_flat,
  input  logic [COORD_W*NUM_BULLETS-1:0] bullet_y_flat,
  input  logic [NUM_BULLETS-1:0]         bullet_active,
  output logic                           busy,
  output logic                           done,
  output logic                           tank_hit,
  output logic [3:0]                     hit_idx,
  output logic                           kill_valid,
  output logic [3:0]                     kill_idx,
  output logic                           overrun
);

  localparam int unsigned     EXT_W    = COORD_W + 1;
  localparam int unsigned     CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BULLETS);
  localparam logic [3:0]      NO_HIT   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [COORD_W-1:0]     tx_q;
  logic [COORD_W-1:0]     ty_q;
  logic [COORD_W-1:0]     ts_q;
  logic [COORD_W-1:0]     bx_q [NUM_BULLETS];
  logic [COORD_W-1:0]     by_q [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] act_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       first_q;
  logic                   found_q;

  logic [EXT_W-1:0] lo_x, hi_x, lo_y, hi_y;
  logic [EXT_W-1:0] cur_bx, cur_by;
  logic [CNT_W-1:0] slot_sel;
  logic             in_range;
  logic             slot_hit;
  logic             scan_end;

  // Inclusive box bounds; lower clamps at zero, upper carries into the extra bit.
  assign lo_x = (tx_q >= ts_q) ? (EXT_W'(tx_q) - EXT_W'(ts_q)) : '0;
  assign hi_x = EXT_W'(tx_q) + EXT_W'(ts_q);
  assign lo_y = (ty_q >= ts_q) ? (EXT_W'(ty_q) - EXT_W'(ts_q)) : '0;
  assign hi_y = EXT_W'(ty_q) + EXT_W'(ts_q);

  // The counter runs one past the last slot so the final kill pulse lands before DONE.
  assign in_range = (cnt_q < LAST_CNT);
  assign slot_sel = in_range ? cnt_q : '0;
  assign cur_bx   = EXT_W'(bx_q[slot_sel]);
  assign cur_by   = EXT_W'(by_q[slot_sel]);
  assign slot_hit = in_range && act_q[slot_sel] &&
                    (cur_bx >= lo_x) && (cur_bx <= hi_x) &&
                    (cur_by >= lo_y) && (cur_by <= hi_y);

`ifdef TB_SCHED_EARLY_EXIT_EN
  assign scan_end = (cnt_q == LAST_CNT) || kill_valid;
`else
  assign scan_end = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      tx_q       <= '0;
      ty_q       <= '0;
      ts_q       <= '0;
      for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
      act_q      <= '0;
      cnt_q      <= '0;
      first_q    <= NO_HIT;
      found_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tank_hit   <= 1'b0;
      hit_idx    <= NO_HIT;
      kill_valid <= 1'b0;
      kill_idx   <= '0;
      overrun    <= 1'b0;
    end else begin
      done       <= 1'b0;
      kill_valid <= 1'b0;
      if (frame_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            tx_q <= Tank_X_Pos;
            ty_q <= Tank_Y_Pos;
            ts_q <= Tank_Size;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
              bx_q[i] <= bullet_x_flat[i*COORD_W +: COORD_W];
              by_q[i] <= bullet_y_flat[i*COORD_W +: COORD_W];
            end
            act_q   <= bullet_active;
            cnt_q   <= '0;
            first_q <= NO_HIT;
            found_q <= 1'b0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (scan_end) begin
            done     <= 1'b1;
            tank_hit <= found_q;
            hit_idx  <= first_q;
            state    <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (slot_hit) begin
              kill_valid <= 1'b1;
              kill_idx   <= cnt_q;
              if (!found_q) begin
                found_q <= 1'b1;
                first_q <= cnt_q;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_collision_sched.sv
// Bench for tb_collision_sched: directed scenarios plus random frames against a box-test model.
module tb_tb_collision_sched;

  localparam int unsigned NB = 12;
  localparam int unsigned CW = 10;
`ifdef TB_SCHED_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic [CW-1:0]    tank_x, tank_y, tank_s;
  logic [CW*NB-1:0] bx_flat, by_flat;
  logic [NB-1:0]    b_act;
  logic             busy, done, tank_hit, kill_valid, overrun;
  logic [3:0]       hit_idx, kill_idx;

  int total = 0;
  int bad   = 0;

  int tx, ty, ts;
  int bxa [NB];
  int bya [NB];
  bit acta[NB];

  int          obs_done_cyc, obs_done_cnt, obs_kcnt, obs_busy_cnt;
  logic        obs_busy1, obs_busy_after, obs_hit, obs_ovr;
  logic [3:0]  obs_idx;
  logic [15:0] obs_kmask;
  logic [63:0] obs_ktime;

  int          exp_done, exp_kcnt;
  logic        exp_hit;
  logic [3:0]  exp_idx;
  logic [15:0] exp_kmask;
  logic [63:0] exp_ktime;

  tb_collision_sched #(.NUM_BULLETS(NB), .COORD_W(CW)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .frame_start  (frame_start),
    .Tank_X_Pos   (tank_x),
    .Tank_Y_Pos   (tank_y),
    .Tank_Size    (tank_s),
    .bullet_x_flat(bx_flat),
    .bullet_y_flat(by_flat),
    .bullet_active(b_act),
    .busy         (busy),
    .done         (done),
    .tank_hit     (tank_hit),
    .hit_idx      (hit_idx),
    .kill_valid   (kill_valid),
    .kill_idx     (kill_idx),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_inputs();
    tank_x = CW'(tx);
    tank_y = CW'(ty);
    tank_s = CW'(ts);
    for (int i = 0; i < NB; i++) begin
      bx_flat[i*CW +: CW] = CW'(bxa[i]);
      by_flat[i*CW +: CW] = CW'(bya[i]);
      b_act[i]            = acta[i];
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NB; i++) begin
      bxa[i] = 0; bya[i] = 0; acta[i] = 1'b0;
    end
  endtask

  // A slot hits when |b - centre| <= size on both axes, using unbounded integers.
  task automatic model();
    exp_kmask = '0; exp_ktime = '0; exp_kcnt = 0; exp_hit = 1'b0; exp_idx = 4'hF;
    for (int i = 0; i < NB; i++) begin
      if (acta[i] && bxa[i] >= tx - ts && bxa[i] <= tx + ts &&
          bya[i] >= ty - ts && bya[i] <= ty + ts) begin
        if (!EARLY || exp_kcnt == 0) begin
          exp_kmask[i]   = 1'b1;
          exp_ktime[i+1] = 1'b1;
          exp_kcnt++;
        end
        if (!exp_hit) begin
          exp_hit = 1'b1;
          exp_idx = 4'(i);
        end
      end
    end
    exp_done = (EARLY && exp_hit) ? int'(exp_idx) + 2 : NB + 1;
  endtask

  task automatic scramble();
    tx = int'($urandom_range(0, 1023));
    ty = int'($urandom_range(0, 1023));
    ts = 30;
    for (int i = 0; i < NB; i++) begin
      bxa[i] = tx; bya[i] = ty; acta[i] = 1'b1;
    end
    apply_inputs();
  endtask

  // Launches one frame and records what the DUT does until the cycle after done.
  task automatic do_scan(input int chg_at, input int fs_at);
    model();
    obs_done_cyc = 0; obs_done_cnt = 0; obs_kcnt = 0; obs_busy_cnt = 0;
    obs_kmask = '0; obs_ktime = '0; obs_busy1 = 1'b0; obs_busy_after = 1'b1;
    @(negedge clk);
    apply_inputs();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) obs_busy1 = busy;
      if (busy) obs_busy_cnt++;
      if (kill_valid) begin
        obs_kcnt++;
        obs_kmask[kill_idx] = 1'b1;
        obs_ktime[k]        = 1'b1;
      end
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) obs_done_cyc = k;
      end
      frame_start = (k == fs_at);
      if (k == chg_at) scramble();
      if (obs_done_cyc != 0 && k > obs_done_cyc) begin
        obs_busy_after = busy;
        break;
      end
    end
    frame_start = 1'b0;
    obs_hit = tank_hit;
    obs_idx = hit_idx;
    obs_ovr = overrun;
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, tank_hit, hit_idx, kill_valid, kill_idx, overrun} !==
        {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals got busy=%b done=%b hit=%b idx=%h kv=%b ki=%h ovr=%b exp 0 0 0 f 0 0 0",
               busy, done, tank_hit, hit_idx, kill_valid, kill_idx, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, hit_idx} !== {1'b0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b idx=%h exp 0 0 f", busy, done, hit_idx);
    end
  endtask

  task automatic test_single_hit();
    tx = 100; ty = 100; ts = 8; clear_slots();
    bxa[3] = 108; bya[3] = 92; acta[3] = 1'b1;
    do_scan(0, 0);
    total++;
    if ({obs_kmask, obs_ktime} !== {16'h0008, 64'h10}) begin
      bad++;
      $display("FAIL single_kill got mask=%h time=%h exp mask=0008 time=10", obs_kmask, obs_ktime);
    end
    total++;
    if (obs_done_cyc !== exp_done || obs_done_cnt !== 1) begin
      bad++;
      $display("FAIL single_done got cyc=%0d cnt=%0d exp cyc=%0d cnt=1", obs_done_cyc, obs_done_cnt, exp_done);
    end
    total++;
    if ({obs_hit, obs_idx} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL single_result got hit=%b idx=%h exp 1 3", obs_hit, obs_idx);
    end
    total++;
    if (obs_busy_cnt !== exp_done || obs_busy1 !== 1'b1) begin
      bad++;
      $display("FAIL single_busy got cycles=%0d first=%b exp %0d 1", obs_busy_cnt, obs_busy1, exp_done);
    end
  endtask

  task automatic test_edge_miss();
    tx = 100; ty = 100; ts = 8; clear_slots();
    bxa[3] = 109; bya[3] = 100; acta[3] = 1'b1;
    do_scan(0, 0);
    total++;
    if (obs_kcnt !== 0 || obs_kmask !== 16'h0) begin
      bad++;
      $display("FAIL miss_kill got cnt=%0d mask=%h exp 0 0000", obs_kcnt, obs_kmask);
    end
    total++;
    if ({obs_hit, obs_idx} !== {1'b0, 4'hF} || obs_done_cyc !== NB + 1) begin
      bad++;
      $display("FAIL miss_result got hit=%b idx=%h cyc=%0d exp 0 f %0d", obs_hit, obs_idx, obs_done_cyc, NB + 1);
    end
  endtask

  task automatic test_clamp_multi();
    tx = 4; ty = 4; ts = 8; clear_slots();
    bxa[0] = 0;  bya[0] = 0;  acta[0] = 1'b1;
    bxa[5] = 12; bya[5] = 12; acta[5] = 1'b1;
    do_scan(0, 0);
    total++;
    if (obs_kmask !== (EARLY ? 16'h0001 : 16'h0021) || obs_ktime !== exp_ktime) begin
      bad++;
      $display("FAIL clamp_kill got mask=%h time=%h exp mask=%h time=%h",
               obs_kmask, obs_ktime, EARLY ? 16'h0001 : 16'h0021, exp_ktime);
    end
    total++;
    if (obs_done_cyc !== (EARLY ? 2 : 13) || {obs_hit, obs_idx} !== {1'b1, 4'd0}) begin
      bad++;
      $display("FAIL clamp_done got cyc=%0d hit=%b idx=%h exp %0d 1 0",
               obs_done_cyc, obs_hit, obs_idx, EARLY ? 2 : 13);
    end
  endtask

  task automatic test_inactive_snapshot();
    tx = 100; ty = 100; ts = 8; clear_slots();
    bxa[2] = 100; bya[2] = 100; acta[2] = 1'b0;
    bxa[6] = 95;  bya[6] = 105; acta[6] = 1'b1;
    bxa[9] = 120; bya[9] = 100; acta[9] = 1'b1;
    do_scan(3, 0);
    total++;
    if ({obs_kmask, obs_ktime} !== {16'h0040, 64'h80}) begin
      bad++;
      $display("FAIL snapshot_kill got mask=%h time=%h exp 0040 80", obs_kmask, obs_ktime);
    end
    total++;
    if ({obs_hit, obs_idx} !== {1'b1, 4'd6} || obs_done_cyc !== exp_done) begin
      bad++;
      $display("FAIL snapshot_result got hit=%b idx=%h cyc=%0d exp 1 6 %0d", obs_hit, obs_idx, obs_done_cyc, exp_done);
    end
  endtask

  task automatic test_random();
    int off;
    for (int n = 0; n < 25; n++) begin
      tx = int'($urandom_range(0, 1023));
      ty = int'($urandom_range(0, 1023));
      ts = int'($urandom_range(0, 60));
      for (int i = 0; i < NB; i++) begin
        off    = int'($urandom_range(0, 2 * (ts + 2))) - (ts + 2);
        bxa[i] = (tx + off < 0) ? 0 : ((tx + off > 1023) ? 1023 : tx + off);
        off    = int'($urandom_range(0, 2 * (ts + 2))) - (ts + 2);
        bya[i] = (ty + off < 0) ? 0 : ((ty + off > 1023) ? 1023 : ty + off);
        acta[i] = ($urandom_range(0, 3) != 0);
      end
      do_scan(0, 0);
      total++;
      if ({obs_kmask, obs_ktime} !== {exp_kmask, exp_ktime} || obs_kcnt !== exp_kcnt) begin
        bad++;
        $display("FAIL rand%0d_kill got mask=%h time=%h cnt=%0d exp %h %h %0d",
                 n, obs_kmask, obs_ktime, obs_kcnt, exp_kmask, exp_ktime, exp_kcnt);
      end
      total++;
      if ({obs_hit, obs_idx} !== {exp_hit, exp_idx} || obs_done_cyc !== exp_done ||
          obs_done_cnt !== 1 || obs_ovr !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_result got hit=%b idx=%h cyc=%0d cnt=%0d ovr=%b exp %b %h %0d 1 0",
                 n, obs_hit, obs_idx, obs_done_cyc, obs_done_cnt, obs_ovr, exp_hit, exp_idx, exp_done);
      end
    end
  endtask

  task automatic test_overrun();
    tx = 100; ty = 100; ts = 8; clear_slots();
    bxa[3] = 108; bya[3] = 92; acta[3] = 1'b1;
    do_scan(0, 5);
    total++;
    if (obs_done_cyc !== exp_done || obs_done_cnt !== 1 || obs_ovr !== 1'b1) begin
      bad++;
      $display("FAIL overrun got cyc=%0d cnt=%0d ovr=%b exp %0d 1 1", obs_done_cyc, obs_done_cnt, obs_ovr, exp_done);
    end
    total++;
    if ({obs_hit, obs_idx} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL overrun_result got hit=%b idx=%h exp 1 3", obs_hit, obs_idx);
    end
  endtask

  task automatic test_done_coincident();
    int extra_busy;
    tx = 300; ty = 200; ts = 5; clear_slots();
    bxa[1] = 305; bya[1] = 195; acta[1] = 1'b1;
    model();
    do_scan(0, exp_done);
    extra_busy = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (busy || done) extra_busy++;
    end
    total++;
    if (obs_busy_after !== 1'b0 || extra_busy !== 0 || obs_done_cnt !== 1) begin
      bad++;
      $display("FAIL done_coincident got busy_after=%b extra=%0d dones=%0d exp 0 0 1",
               obs_busy_after, extra_busy, obs_done_cnt);
    end
    total++;
    if ({obs_hit, obs_idx} !== {1'b1, 4'd1}) begin
      bad++;
      $display("FAIL done_coincident_result got hit=%b idx=%h exp 1 1", obs_hit, obs_idx);
    end
  endtask

  task automatic test_reset_midscan();
    int seen_done;
    tx = 100; ty = 100; ts = 8; clear_slots();
    bxa[10] = 100; bya[10] = 100; acta[10] = 1'b1;
    @(negedge clk);
    apply_inputs();
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, tank_hit, hit_idx, kill_valid, kill_idx, overrun} !==
        {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL midscan_reset got busy=%b done=%b hit=%b idx=%h kv=%b ki=%h ovr=%b exp 0 0 0 f 0 0 0",
               busy, done, tank_hit, hit_idx, kill_valid, kill_idx, overrun);
    end
    seen_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    total++;
    if (seen_done !== 0) begin
      bad++;
      $display("FAIL midscan_no_done got active_cycles=%0d exp 0", seen_done);
    end
  endtask

  task automatic test_restart();
    tx = 50; ty = 60; ts = 3; clear_slots();
    bxa[0] = 47; bya[0] = 63; acta[0] = 1'b1;
    do_scan(0, 0);
    total++;
    if (obs_busy1 !== 1'b1 || obs_done_cyc !== exp_done) begin
      bad++;
      $display("FAIL restart got busy1=%b cyc=%0d exp 1 %0d", obs_busy1, obs_done_cyc, exp_done);
    end
    total++;
    if ({obs_hit, obs_idx, obs_kmask} !== {1'b1, 4'd0, 16'h0001}) begin
      bad++;
      $display("FAIL restart_result got hit=%b idx=%h mask=%h exp 1 0 0001", obs_hit, obs_idx, obs_kmask);
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    tx = 0; ty = 0; ts = 0;
    clear_slots();
    apply_inputs();
    repeat (3) @(negedge clk);
    test_reset();
    test_single_hit();
    test_edge_miss();
    test_clamp_multi();
    test_inactive_snapshot();
    test_random();
    test_overrun();
    test_done_coincident();
    test_reset_midscan();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
